// File: rtl/reg_writeback_pkg.sv
// Shared definitions for the register writeback stage: data width,
// writeback source encoding and the {rd, data} record carried by the
// load buffer. Optional forwarding is controlled by macro WB_BYPASS_EN.
package reg_writeback_pkg;

  localparam int XLEN        = 32;
  localparam int MAX_BIT_POS = XLEN - 1;
  localparam int RD_W        = 5;

  // Which path wins the single register file write port this cycle.
  typedef enum logic [1:0] {
    WB_SRC_NONE = 2'd0,
    WB_SRC_ALU  = 2'd1,
    WB_SRC_LD   = 2'd2,
    WB_SRC_CSR  = 2'd3
  } wb_src_e;

  // One pending result: destination register plus value.
  typedef struct packed {
    logic [RD_W-1:0]      rd;
    logic [MAX_BIT_POS:0] data;
  } wb_rec_t;

  localparam int REC_W = $bits(wb_rec_t);

endpackage

// File: rtl/reg_writeback_wb_ld_fifo.sv
// Small synchronous FIFO for buffered load results. The head entry is
// visible combinationally so the arbiter can write it the same cycle it pops.
// A push is accepted while full if a pop happens in the same cycle.
module wb_ld_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 37
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW:0]      count_reg;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_reg == (AW+1)'(DEPTH));
  assign empty   = (count_reg == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr_reg];

  // Storage array; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  // Pointer and occupancy tracking; DEPTH is a power of two so pointers wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/reg_writeback.sv
// Writeback stage: arbitrates ALU, load and CSR results onto the single
// registered register file write port and tracks pending destination
// registers for decode hazard checks. Define WB_BYPASS_EN to forward the
// value currently being written to matching source operands.
module reg_writeback
  import reg_writeback_pkg::*;
#(
  parameter int LD_DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 alu_valid,
  input  logic [4:0]           alu_rd,
  input  logic [MAX_BIT_POS:0] alu_data,
  input  logic                 ld_valid,
  output logic                 ld_ready,
  input  logic [4:0]           ld_rd,
  input  logic [MAX_BIT_POS:0] ld_data,
  input  logic                 csr_valid,
  output logic                 csr_ready,
  input  logic [4:0]           csr_rd,
  input  logic [MAX_BIT_POS:0] csr_data,
  input  logic                 issue_en,
  input  logic [4:0]           issue_rd,
  input  logic [4:0]           rs1_addr,
  input  logic [4:0]           rs2_addr,
  output logic                 rs1_busy,
  output logic                 rs2_busy,
  output logic                 rs1_fwd,
  output logic                 rs2_fwd,
  output logic [MAX_BIT_POS:0] rs1_fwd_data,
  output logic [MAX_BIT_POS:0] rs2_fwd_data,
  output logic [4:0]           rd_addr,
  output logic [MAX_BIT_POS:0] rd_data,
  output logic                 rd_en
);

  logic                 fifo_push;
  logic                 fifo_pop;
  logic                 fifo_full;
  logic                 fifo_empty;
  wb_rec_t              fifo_head;
  wb_rec_t              ld_rec;
  wb_src_e              src_sel;
  logic                 ld_bypass;
  wb_rec_t              win_rec;
  logic                 win_valid;

  logic                 rd_en_reg;
  logic [4:0]           rd_addr_reg;
  logic [MAX_BIT_POS:0] rd_data_reg;
  logic [31:0]          pending_reg;
  logic [31:0]          pending_next;

  assign ld_rec    = '{rd: ld_rd, data: ld_data};
  assign ld_ready  = !rst && !fifo_full;
  assign csr_ready = !rst && !alu_valid && fifo_empty && !ld_valid;

  wb_ld_fifo #(
    .DEPTH (LD_DEPTH),
    .WIDTH (REC_W)
  ) u_ld_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (ld_rec),
    .pop       (fifo_pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (fifo_head)
  );

  // Fixed-priority arbitration: ALU, buffered load, bypassed load, CSR.
  always_comb begin
    src_sel   = WB_SRC_NONE;
    fifo_pop  = 1'b0;
    ld_bypass = 1'b0;
    if (!rst) begin
      if (alu_valid) begin
        src_sel = WB_SRC_ALU;
      end else if (!fifo_empty) begin
        src_sel  = WB_SRC_LD;
        fifo_pop = 1'b1;
      end else if (ld_valid) begin
        src_sel   = WB_SRC_LD;
        ld_bypass = 1'b1;
      end else if (csr_valid) begin
        src_sel = WB_SRC_CSR;
      end
    end
    // Any accepted load that does not go straight out is buffered.
    fifo_push = ld_valid && ld_ready && !ld_bypass;
  end

  // Select the winning record for the write port register.
  always_comb begin
    win_rec = '0;
    case (src_sel)
      WB_SRC_ALU: win_rec = '{rd: alu_rd, data: alu_data};
      WB_SRC_LD:  win_rec = ld_bypass ? ld_rec : fifo_head;
      WB_SRC_CSR: win_rec = '{rd: csr_rd, data: csr_data};
      default:    win_rec = '0;
    endcase
    win_valid = (src_sel != WB_SRC_NONE);
  end

  // Registered write port; an x0 winner is consumed without a write.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_en_reg   <= 1'b0;
      rd_addr_reg <= '0;
      rd_data_reg <= '0;
    end else begin
      rd_en_reg <= win_valid && (win_rec.rd != 5'd0);
      if (win_valid) begin
        rd_addr_reg <= win_rec.rd;
        rd_data_reg <= win_rec.data;
      end
    end
  end

  assign rd_en   = rd_en_reg;
  assign rd_addr = rd_addr_reg;
  assign rd_data = rd_data_reg;

  // Pending vector update: clear on write, set on issue (set wins), x0 never pending.
  always_comb begin
    pending_next = pending_reg;
    if (rd_en_reg) pending_next[rd_addr_reg] = 1'b0;
    if (issue_en)  pending_next[issue_rd]    = 1'b1;
    pending_next[0] = 1'b0;
  end

  // Scoreboard state.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending_reg <= '0;
    end else begin
      pending_reg <= pending_next;
    end
  end

  // Per-source-operand hazard and forwarding checks.
  logic [4:0]           rs_addr_arr  [2];
  logic                 busy_arr     [2];
  logic                 fwd_arr      [2];
  logic [MAX_BIT_POS:0] fwd_data_arr [2];

  assign rs_addr_arr[0] = rs1_addr;
  assign rs_addr_arr[1] = rs2_addr;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_src
`ifdef WB_BYPASS_EN
      assign fwd_arr[gi]      = !rst && rd_en_reg && (rd_addr_reg == rs_addr_arr[gi]) &&
                                (rs_addr_arr[gi] != 5'd0);
      assign fwd_data_arr[gi] = rd_data_reg;
`else
      assign fwd_arr[gi]      = 1'b0;
      assign fwd_data_arr[gi] = '0;
`endif
      assign busy_arr[gi] = !rst && pending_reg[rs_addr_arr[gi]] && !fwd_arr[gi];
    end
  endgenerate

  assign rs1_busy     = busy_arr[0];
  assign rs2_busy     = busy_arr[1];
  assign rs1_fwd      = fwd_arr[0];
  assign rs2_fwd      = fwd_arr[1];
  assign rs1_fwd_data = fwd_data_arr[0];
  assign rs2_fwd_data = fwd_data_arr[1];

endmodule

// File: tb/tb_reg_writeback.sv
// Self-checking bench for reg_writeback: a write scoreboard receives the
// expected {rd, data} writes as stimulus is driven and a monitor pops and
// compares on every rd_en. Each task also checks timing-specific outputs.
module tb_reg_writeback;

  localparam int LD_DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        alu_valid = 1'b0;
  logic [4:0]  alu_rd = '0;
  logic [31:0] alu_data = '0;
  logic        ld_valid = 1'b0;
  logic        ld_ready;
  logic [4:0]  ld_rd = '0;
  logic [31:0] ld_data = '0;
  logic        csr_valid = 1'b0;
  logic        csr_ready;
  logic [4:0]  csr_rd = '0;
  logic [31:0] csr_data = '0;
  logic        issue_en = 1'b0;
  logic [4:0]  issue_rd = '0;
  logic [4:0]  rs1_addr = '0;
  logic [4:0]  rs2_addr = '0;
  logic        rs1_busy, rs2_busy, rs1_fwd, rs2_fwd;
  logic [31:0] rs1_fwd_data, rs2_fwd_data;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data;
  logic        rd_en;

  int n_cmp = 0;
  int n_err = 0;
  logic [36:0] exp_q [$];

  always #5 clk = ~clk;

  reg_writeback #(.LD_DEPTH(LD_DEPTH)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_data(ld_data),
    .csr_valid(csr_valid), .csr_ready(csr_ready), .csr_rd(csr_rd), .csr_data(csr_data),
    .issue_en(issue_en), .issue_rd(issue_rd),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .rs1_fwd(rs1_fwd), .rs2_fwd(rs2_fwd),
    .rs1_fwd_data(rs1_fwd_data), .rs2_fwd_data(rs2_fwd_data),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_en(rd_en)
  );

  // Write monitor: every register file write must match the scoreboard head.
  always @(negedge clk) begin
    if (rd_en === 1'b1) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL wb_write: got x%0d=%h, required no write", rd_addr, rd_data);
      end else begin
        logic [36:0] e;
        e = exp_q.pop_front();
        if ({rd_addr, rd_data} !== e) begin
          n_err++;
          $display("FAIL wb_write: got x%0d=%h, required x%0d=%h", rd_addr, rd_data, e[36:32], e[31:0]);
        end else begin
          $display("write x%0d = %h", rd_addr, rd_data);
        end
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    alu_valid = 1'b0;
    ld_valid  = 1'b0;
    csr_valid = 1'b0;
    issue_en  = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    rs1_addr = 5'd7;
    next_cycle();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_cmp++;
      if (rd_en !== 1'b0 || ld_ready !== 1'b0 || csr_ready !== 1'b0 || rs1_busy !== 1'b0 || rs1_fwd !== 1'b0) begin
        n_err++;
        $display("FAIL reset_hold: got rd_en=%b ld_ready=%b csr_ready=%b busy=%b fwd=%b, required all 0",
                 rd_en, ld_ready, csr_ready, rs1_busy, rs1_fwd);
      end
      next_cycle();
    end
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (ld_ready !== 1'b1 || rd_en !== 1'b0 || rd_addr !== 5'd0 || rd_data !== 32'd0 || rs1_busy !== 1'b0) begin
      n_err++;
      $display("FAIL reset_values: got ld_ready=%b rd_en=%b rd_addr=%0d rd_data=%h busy=%b, required 1 0 0 0 0",
               ld_ready, rd_en, rd_addr, rd_data, rs1_busy);
    end
    $display("reset done");
    next_cycle();
  endtask

  task automatic test_single_alu();
    idle();
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'h1234;
    exp_q.push_back({5'd5, 32'h1234});
    next_cycle();
    idle();
    @(negedge clk);
    n_cmp++;
    if (rd_en !== 1'b1 || rd_addr !== 5'd5 || rd_data !== 32'h1234) begin
      n_err++;
      $display("FAIL single_alu_latency: got rd_en=%b x%0d=%h, required 1 x5=00001234", rd_en, rd_addr, rd_data);
    end
    next_cycle();
    @(negedge clk);
    n_cmp++;
    if (rd_en !== 1'b0) begin
      n_err++;
      $display("FAIL single_alu_once: got rd_en=%b, required 0", rd_en);
    end
    next_cycle();
  endtask

  task automatic test_contention();
    idle();
    alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'h0000_0011;
    ld_valid  = 1'b1; ld_rd  = 5'd2; ld_data  = 32'h0000_0022;
    exp_q.push_back({5'd1, 32'h0000_0011});
    exp_q.push_back({5'd2, 32'h0000_0022});
    @(negedge clk);
    n_cmp++;
    if (ld_ready !== 1'b1) begin
      n_err++;
      $display("FAIL contention_ready: got ld_ready=%b, required 1", ld_ready);
    end
    next_cycle();
    idle();
    @(negedge clk);
    n_cmp++;
    if (rd_en !== 1'b1 || rd_addr !== 5'd1 || ld_ready !== 1'b1) begin
      n_err++;
      $display("FAIL contention_first: got rd_en=%b x%0d ld_ready=%b, required 1 x1 1", rd_en, rd_addr, ld_ready);
    end
    next_cycle();
    @(negedge clk);
    n_cmp++;
    if (rd_en !== 1'b1 || rd_addr !== 5'd2) begin
      n_err++;
      $display("FAIL contention_second: got rd_en=%b x%0d, required 1 x2", rd_en, rd_addr);
    end
    next_cycle();
  endtask

  task automatic test_ld_full();
    logic [36:0] lq [$];
    int sent = 0;
    for (int c = 0; c < 16; c++) begin
      idle();
      if (c < 6) begin
        alu_valid = 1'b1; alu_rd = 5'(10 + c); alu_data = 32'hA000_0000 + 32'(c);
        exp_q.push_back({alu_rd, alu_data});
      end
      if (sent < 4) begin
        ld_valid = 1'b1; ld_rd = 5'(20 + sent); ld_data = 32'hB000_0000 + 32'(sent);
      end
      @(negedge clk);
      if (c == 0) begin
        n_cmp++;
        if (ld_ready !== 1'b1) begin
          n_err++;
          $display("FAIL ld_full_start: got ld_ready=%b, required 1", ld_ready);
        end
      end
      if (c == 3) begin
        n_cmp++;
        if (ld_ready !== 1'b0) begin
          n_err++;
          $display("FAIL ld_full_ready: got ld_ready=%b, required 0 with %0d loads buffered", ld_ready, LD_DEPTH);
        end
      end
      if (ld_valid && ld_ready) begin
        lq.push_back({ld_rd, ld_data});
        sent++;
      end
      // Loads only reach the port once the ALU stops; queue them after the ALU writes.
      if (!alu_valid) begin
        while (lq.size() > 0) exp_q.push_back(lq.pop_front());
      end
      next_cycle();
    end
    n_cmp++;
    if (sent !== 4) begin
      n_err++;
      $display("FAIL ld_full_accepted: got %0d loads accepted, required 4", sent);
    end
  endtask

  task automatic test_x0_drop();
    idle();
    rs1_addr = 5'd0;
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hDEAD_BEEF;
    issue_en = 1'b1; issue_rd = 5'd0;
    next_cycle();
    idle();
    @(negedge clk);
    n_cmp++;
    if (rd_en !== 1'b0 || rs1_busy !== 1'b0) begin
      n_err++;
      $display("FAIL x0_drop: got rd_en=%b busy=%b, required 0 0", rd_en, rs1_busy);
    end
    next_cycle();
    @(negedge clk);
    n_cmp++;
    if (rs1_busy !== 1'b0) begin
      n_err++;
      $display("FAIL x0_pending: got busy=%b, required 0", rs1_busy);
    end
    next_cycle();
  endtask

  task automatic test_scoreboard();
    idle();
    rs1_addr = 5'd7; rs2_addr = 5'd8;
    issue_en = 1'b1; issue_rd = 5'd7;
    next_cycle();
    idle();
    @(negedge clk);
    n_cmp++;
    if (rs1_busy !== 1'b1 || rs2_busy !== 1'b0) begin
      n_err++;
      $display("FAIL sb_set: got rs1_busy=%b rs2_busy=%b, required 1 0", rs1_busy, rs2_busy);
    end
    next_cycle();
    alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'hABCD_0007;
    exp_q.push_back({5'd7, 32'hABCD_0007});
    @(negedge clk);
    n_cmp++;
    if (rs1_busy !== 1'b1) begin
      n_err++;
      $display("FAIL sb_hold: got rs1_busy=%b, required 1", rs1_busy);
    end
    next_cycle();
    idle();
    @(negedge clk);
    n_cmp++;
`ifdef WB_BYPASS_EN
    if (rs1_fwd !== 1'b1 || rs1_busy !== 1'b0 || rs1_fwd_data !== 32'hABCD_0007 || rs2_fwd !== 1'b0) begin
      n_err++;
      $display("FAIL sb_write_cycle: got fwd=%b busy=%b fwd_data=%h rs2_fwd=%b, required 1 0 abcd0007 0",
               rs1_fwd, rs1_busy, rs1_fwd_data, rs2_fwd);
    end
`else
    if (rs1_fwd !== 1'b0 || rs1_busy !== 1'b1 || rs1_fwd_data !== 32'd0) begin
      n_err++;
      $display("FAIL sb_write_cycle: got fwd=%b busy=%b fwd_data=%h, required 0 1 0", rs1_fwd, rs1_busy, rs1_fwd_data);
    end
`endif
    next_cycle();
    @(negedge clk);
    n_cmp++;
    if (rs1_busy !== 1'b0) begin
      n_err++;
      $display("FAIL sb_clear: got rs1_busy=%b, required 0", rs1_busy);
    end
    next_cycle();
    // Set and clear of x9 on the same edge: the set must survive.
    rs1_addr = 5'd9;
    alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h0000_00D9;
    exp_q.push_back({5'd9, 32'h0000_00D9});
    next_cycle();
    idle();
    issue_en = 1'b1; issue_rd = 5'd9;
    next_cycle();
    idle();
    @(negedge clk);
    n_cmp++;
    if (rs1_busy !== 1'b1) begin
      n_err++;
      $display("FAIL sb_set_wins: got rs1_busy=%b, required 1", rs1_busy);
    end
    next_cycle();
    alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h0000_00E9;
    exp_q.push_back({5'd9, 32'h0000_00E9});
    next_cycle();
    idle();
    next_cycle();
    @(negedge clk);
    n_cmp++;
    if (rs1_busy !== 1'b0) begin
      n_err++;
      $display("FAIL sb_set_wins_clear: got rs1_busy=%b, required 0", rs1_busy);
    end
    next_cycle();
  endtask

  task automatic test_csr();
    idle();
    alu_valid = 1'b1; alu_rd = 5'd11; alu_data = 32'hC0DE_0011;
    csr_valid = 1'b1; csr_rd = 5'd12; csr_data = 32'hC5C5_0012;
    exp_q.push_back({5'd11, 32'hC0DE_0011});
    @(negedge clk);
    n_cmp++;
    if (csr_ready !== 1'b0) begin
      n_err++;
      $display("FAIL csr_blocked: got csr_ready=%b, required 0", csr_ready);
    end
    next_cycle();
    alu_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (csr_ready !== 1'b1) begin
      n_err++;
      $display("FAIL csr_accept: got csr_ready=%b, required 1", csr_ready);
    end
    if (csr_ready === 1'b1) exp_q.push_back({5'd12, 32'hC5C5_0012});
    next_cycle();
    idle();
    @(negedge clk);
    n_cmp++;
    if (rd_en !== 1'b1 || rd_addr !== 5'd12) begin
      n_err++;
      $display("FAIL csr_write: got rd_en=%b x%0d, required 1 x12", rd_en, rd_addr);
    end
    next_cycle();
  endtask

  task automatic test_ld_bypass();
    idle();
    ld_valid = 1'b1; ld_rd = 5'd13; ld_data = 32'h1D1D_0013;
    @(negedge clk);
    n_cmp++;
    if (ld_ready !== 1'b1) begin
      n_err++;
      $display("FAIL ld_bypass_ready: got ld_ready=%b, required 1", ld_ready);
    end
    if (ld_ready === 1'b1) exp_q.push_back({5'd13, 32'h1D1D_0013});
    next_cycle();
    idle();
    @(negedge clk);
    n_cmp++;
    if (rd_en !== 1'b1 || rd_addr !== 5'd13 || rd_data !== 32'h1D1D_0013) begin
      n_err++;
      $display("FAIL ld_bypass_latency: got rd_en=%b x%0d=%h, required 1 x13=1d1d0013", rd_en, rd_addr, rd_data);
    end
    next_cycle();
  endtask

  task automatic test_drain(input string tag);
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) next_cycle();
    n_cmp++;
    if (exp_q.size() !== 0) begin
      n_err++;
      $display("FAIL drain_%s: got %0d writes outstanding, required 0", tag, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset_mid();
    idle();
    rs1_addr = 5'd3;
    issue_en = 1'b1; issue_rd = 5'd3;
    alu_valid = 1'b1; alu_rd = 5'd14; alu_data = 32'h0000_0014;
    ld_valid  = 1'b1; ld_rd  = 5'd15; ld_data  = 32'h0000_0015;
    exp_q.push_back({5'd14, 32'h0000_0014});
    next_cycle();
    issue_en = 1'b0;
    alu_rd = 5'd16; alu_data = 32'h0000_0016;
    ld_rd  = 5'd17; ld_data  = 32'h0000_0017;
    exp_q.push_back({5'd16, 32'h0000_0016});
    next_cycle();
    idle();
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (ld_ready !== 1'b0 || rs1_busy !== 1'b0) begin
      n_err++;
      $display("FAIL reset_mid_hold: got ld_ready=%b busy=%b, required 0 0", ld_ready, rs1_busy);
    end
    next_cycle();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      n_cmp++;
      if (rd_en !== 1'b0 || rs1_busy !== 1'b0 || ld_ready !== 1'b1) begin
        n_err++;
        $display("FAIL reset_mid_after[%0d]: got rd_en=%b busy=%b ld_ready=%b, required 0 0 1",
                 i, rd_en, rs1_busy, ld_ready);
      end
      next_cycle();
    end
  endtask

  initial begin
    test_reset();
    test_single_alu();
    test_contention();
    test_ld_full();
    test_drain("ld_full");
    test_x0_drop();
    test_scoreboard();
    test_csr();
    test_ld_bypass();
    test_drain("pre_reset");
    test_reset_mid();
    test_drain("final");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: got no finish, required finish within 200000 time units");
    $fatal(1);
  end

endmodule
